unpadding: RTL and testbench
============================

# unpadding

Streaming border-removal block: accepts a row-major pixel stream of a padded (OUTPUT_SIZE+2·PAD)² frame and emits only the interior OUTPUT_SIZE² pixels, in order. It sits after each padded convolution/pooling stage and converts padded feature maps back to their unpadded geometry. Ready/valid handshakes on both sides give one pixel per cycle with full backpressure.

## Interface
- OUTPUT_SIZE, 62, interior edge length (pixels emitted per row/column)
- PAD, 1, border width removed on each side
- PIXEL_BITS, 4, pixel width
- PAD_VALUE, 1, expected border pixel value (used only by border check)
- INPUT_SIZE, OUTPUT_SIZE+2*PAD, derived padded edge length; not overridden
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  arms one frame; sampled only in IDLE
- in_valid  in  1  input pixel valid
- in_data  in  PIXEL_BITS  input pixel
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- out_valid  out  1  output pixel valid
- out_data  out  PIXEL_BITS  interior pixel
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_last  out  1  high with the final interior pixel of the frame
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at frame completion
- border_err  out  1  sticky border-mismatch flag (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0; start=1 → RUN next cycle; row/col counters cleared to 0, border_err cleared.
- RUN: row/col counters (width clog2(INPUT_SIZE)) advance on each input accept; col wraps INPUT_SIZE-1→0 with row+1.
- Pixel is interior iff PAD ≤ row < INPUT_SIZE-PAD and PAD ≤ col < INPUT_SIZE-PAD.
- Border pixels: in_ready=1 unconditionally in RUN; accepted and discarded.
- Interior pixels: in_ready = !out_valid || out_ready (single output register, no bubble under continuous ready).
- Interior accept loads out_data, sets out_valid; out_last=1 iff (row,col)=(INPUT_SIZE-PAD-1, INPUT_SIZE-PAD-1).
- out_valid/out_data/out_last held stable while out_valid && !out_ready.
- Accept at (INPUT_SIZE-1, INPUT_SIZE-1) → DRAIN (in_ready=0 from next cycle).
- DRAIN: wait until output register empty (or being emptied this cycle) → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored; input beats while not RUN are not accepted.
- Reset mid-frame: all state discarded immediately, outputs to reset values; partial frame lost.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, border_err=0; state IDLE.
- start in cycle N → in_ready may be 1 in cycle N+1.
- Latency: interior pixel accepted in cycle N → out_valid in cycle N+1.
- Throughput: 1 input pixel/cycle with out_ready=1; frame takes INPUT_SIZE² accept cycles.
- Simultaneous output pop and interior push in same cycle: both occur, out_valid stays 1.
- done asserts earliest 2 cycles after the final input accept (DRAIN, then DONE), later under backpressure.

## Configuration
- UNPAD_BORDER_CHECK_EN defined: every discarded border pixel compared to PAD_VALUE; mismatch sets border_err the cycle after accept, sticky until next start or reset.
- Undefined: no comparator; border_err tied 0; datapath behaviour identical.

## Test plan
- OUTPUT_SIZE=2, PAD=1: stream values 0..15, out_ready=1 → outputs exactly 5,6,9,10; out_last with 10; done pulses once.
- Same frame, out_ready toggling 1/0 each cycle → same 4 values in order, no drop/duplication, out_data stable while stalled.
- in_valid gaps (valid every 3rd cycle) → same outputs; counters advance only on accept.
- Macro defined, border pixel at index 3 = 7 with PAD_VALUE=1 → border_err=1 after that accept, stays 1 through done; cleared on next start.
- rst_n low after 6 accepts → all outputs zero immediately; next start + full frame gives correct 5,6,9,10.
- start pulsed during RUN → ignored; frame completes normally with one done pulse.

Source files
------------

// File: rtl/unpadding.sv
// unpadding: streaming border removal for a padded square frame.
// Accepts a row-major (OUTPUT_SIZE+2*PAD)^2 pixel stream and forwards only the
// interior OUTPUT_SIZE^2 pixels through a single output register with
// ready/valid handshakes on both sides.
// Optional feature: define UNPAD_BORDER_CHECK_EN to compare every discarded
// border pixel against PAD_VALUE and raise a sticky border_err on mismatch.

module unpadding #(
  parameter int unsigned OUTPUT_SIZE = 62,
  parameter int unsigned PAD         = 1,
  parameter int unsigned PIXEL_BITS  = 4,
  parameter int unsigned PAD_VALUE   = 1,
  parameter int unsigned INPUT_SIZE  = OUTPUT_SIZE + 2 * PAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [PIXEL_BITS-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [PIXEL_BITS-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  border_err
);

  localparam int unsigned CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [CW-1:0] LoIdx   = CW'(PAD);
  localparam logic [CW-1:0] HiIdx   = CW'(INPUT_SIZE - PAD);
  localparam logic [CW-1:0] LastIdx = CW'(INPUT_SIZE - 1);
  localparam logic [CW-1:0] LastInt = CW'(INPUT_SIZE - PAD - 1);

  localparam logic [PIXEL_BITS-1:0] PadPix = PIXEL_BITS'(PAD_VALUE);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  out_valid_q;
  logic [PIXEL_BITS-1:0] out_data_q;
  logic                  out_last_q;

  logic interior;
  logic accept;
  logic push;
  logic pop;
  logic frame_end;

  assign interior = (row_q >= LoIdx) && (row_q < HiIdx) &&
                    (col_q >= LoIdx) && (col_q < HiIdx);

  // Border pixels are always swallowed; interior pixels wait for output space.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == StRun) begin
      in_ready = interior ? (!out_valid_q || out_ready) : 1'b1;
    end
  end

  assign accept    = in_valid && in_ready;
  assign push      = accept && interior;
  assign pop       = out_valid_q && out_ready;
  assign frame_end = accept && (row_q == LastIdx) && (col_q == LastIdx);

  // Next-state and raster position counters.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == LastIdx) begin
            col_d = '0;
            row_d = (row_q == LastIdx) ? '0 : row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (frame_end) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave once the output register is empty or drains this cycle.
        if (!out_valid_q || out_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Single-entry output register; a push wins over a simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (push) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data;
      out_last_q  <= (row_q == LastInt) && (col_q == LastInt);
    end else if (pop) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

`ifdef UNPAD_BORDER_CHECK_EN
  logic border_err_q;

  // Sticky mismatch flag for discarded border pixels, cleared on a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_err_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      border_err_q <= 1'b0;
    end else if (accept && !interior && (in_data != PadPix)) begin
      border_err_q <= 1'b1;
    end
  end

  assign border_err = border_err_q;
`else
  // PAD_VALUE only matters to the border checker.
  logic unused_pad_pix;
  assign unused_pad_pix = ^PadPix;
  assign border_err     = 1'b0;
`endif

endmodule

// File: tb/tb_unpadding.sv
// Self-checking bench for unpadding with a 4x4 padded frame (OUTPUT_SIZE=2,
// PAD=1). Reference behaviour is computed from frame geometry: each pixel
// index maps to (row, col) and interior pixels form the expected output queue.

module tb_unpadding;

  localparam int unsigned OSZ  = 2;
  localparam int unsigned PADW = 1;
  localparam int unsigned ISZ  = OSZ + 2 * PADW;
  localparam int unsigned NPIX = ISZ * ISZ;
  localparam int unsigned PADV = 1;

`ifdef UNPAD_BORDER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       border_err;

  int n_vec = 0;
  int n_err = 0;

  unpadding #(
    .OUTPUT_SIZE(OSZ),
    .PAD        (PADW),
    .PIXEL_BITS (4),
    .PAD_VALUE  (PADV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .border_err(border_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_interior(input int idx);
    int r;
    int c;
    r = idx / ISZ;
    c = idx % ISZ;
    return (r >= PADW) && (r < ISZ - PADW) && (c >= PADW) && (c < ISZ - PADW);
  endfunction

  // pmode: 0 = values 0..N-1, 1 = clean border except index 3 = 7, 2 = random
  task automatic build_frame(input int pmode, output logic [3:0] pix[NPIX]);
    for (int i = 0; i < NPIX; i++) begin
      case (pmode)
        0:       pix[i] = 4'(i);
        1:       pix[i] = is_interior(i) ? 4'($urandom_range(0, 15)) : 4'(PADV);
        default: pix[i] = 4'($urandom_range(0, 15));
      endcase
    end
    if (pmode == 1) pix[3] = 4'd7;
  endtask

  // vmode/rmode: 0 = always, 1 = every 3rd / every 2nd cycle, 2 = random
  task automatic run_frame(input int pmode, input int vmode, input int rmode,
                           input bit poke_start);
    logic [3:0] pix[NPIX];
    logic [3:0] exp_q[$];
    logic [3:0] held_data;
    bit         held_last;
    bit         prev_stall;
    bit         prev_push;
    bit         err_exp;
    int         k;
    int         nout;
    int         ndone;
    int         cyc;

    build_frame(pmode, pix);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) if (is_interior(i)) exp_q.push_back(pix[i]);

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", busy, 1'b1);
    check_val("err_cleared_on_start", border_err, 1'b0);

    k = 0; nout = 0; ndone = 0; cyc = 0;
    err_exp = 1'b0; prev_stall = 1'b0; prev_push = 1'b0;
    held_data = '0; held_last = 1'b0;

    while (ndone == 0 && cyc < 400) begin
      case (vmode)
        0:       in_valid = (k < NPIX);
        1:       in_valid = (k < NPIX) && (cyc % 3 == 0);
        default: in_valid = (k < NPIX) && ($urandom_range(0, 2) != 0);
      endcase
      in_data = (k < NPIX) ? pix[k] : 4'($urandom_range(0, 15));
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = poke_start && ($urandom_range(0, 5) == 0);

      @(negedge clk);
      check_val("border_err", border_err, err_exp);
      check_val("busy", busy, !done);
      if (k < NPIX) begin
        if (is_interior(k)) check_val("in_ready_int", in_ready, !out_valid || out_ready);
        else                check_val("in_ready_border", in_ready, 1'b1);
      end else begin
        check_val("in_ready_after_frame", in_ready, 1'b0);
      end
      if (prev_push) check_val("latency_valid", out_valid, 1'b1);
      if (prev_stall) begin
        check_val("stall_valid", out_valid, 1'b1);
        check_val("stall_data", out_data, held_data);
        check_val("stall_last", out_last, held_last);
      end

      prev_push = 1'b0;
      if (in_valid && in_ready) begin
        if (is_interior(k)) prev_push = 1'b1;
        else if (ChkEn && pix[k] != 4'(PADV)) err_exp = 1'b1;
        k++;
      end
      if (out_valid && out_ready) begin
        if (nout < exp_q.size()) begin
          check_val("out_data", out_data, exp_q[nout]);
          check_val("out_last", out_last, nout == exp_q.size() - 1);
        end else begin
          check_val("extra_output", 1'b1, 1'b0);
        end
        nout++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (done) ndone++;
      cyc++;
      @(posedge clk); #1;
    end

    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val("done_seen", ndone, 1);
    check_val("accept_count", k, NPIX);
    check_val("output_count", nout, exp_q.size());
    @(negedge clk);
    check_val("done_one_cycle", done, 1'b0);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_in_ready", in_ready, 1'b0);
    check_val("idle_out_valid", out_valid, 1'b0);
    check_val("err_sticky", border_err, err_exp);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_frame();
    int acc;
    int cyc;
    acc = 0; cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (acc < 6 && cyc < 50) begin
      in_data = 4'(acc) ^ 4'hA;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      cyc++;
      @(posedge clk); #1;
    end
    check_val("partial_accepts", acc, 6);
    rst_n = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 4'd0);
    check_val("rst_out_last", out_last, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_border_err", border_err, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check_val("reset_in_ready", in_ready, 1'b0);
    check_val("reset_out_valid", out_valid, 1'b0);
    check_val("reset_out_data", out_data, 4'd0);
    check_val("reset_out_last", out_last, 1'b0);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_done", done, 1'b0);
    check_val("reset_border_err", border_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("idle_no_accept", in_ready, 1'b0);
    in_valid = 1'b0;

    run_frame(0, 0, 0, 1'b0);   // plain frame, 5,6,9,10
    run_frame(0, 0, 1, 1'b0);   // output stalls every other cycle
    run_frame(0, 1, 0, 1'b0);   // input valid every 3rd cycle
    run_frame(1, 0, 0, 1'b0);   // bad border pixel at index 3
    run_frame(2, 0, 0, 1'b0);   // next start clears the flag
    reset_mid_frame();
    run_frame(0, 0, 0, 1'b0);
    run_frame(2, 2, 2, 1'b1);   // random traffic with stray start pulses
    for (int i = 0; i < 6; i++) run_frame(2, 2, 2, i[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
